mem_access_unit: RTL and testbench

- Initiator side of the single-port data memory used by the pipelined MIPS datapath; sits between the MEM stage and the word-wide data memory.
- Accepts byte, halfword and word load/store requests on a valid/ready handshake.
- Converts each request into word-addressed memory cycles. Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Returns a held response with an error flag for misaligned or out-of-range addresses.

---
 rtl/mem_access_unit_pkg.sv | 19 +
 rtl/mem_access_unit_align.sv | 37 +++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data memory access unit.
package mem_access_unit_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DEPTH_WORDS = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RSP  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_access_unit_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
// Purely combinational; the FSM decides which result is used.
module byte_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rd_word_i,
  input  logic [15:0] wr_lo_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rd_word_i[{lane_i, 3'b000} +: 8];
    half_sel  = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    ld_data_o = rd_word_i;
    merged_o  = rd_word_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merged_o[{lane_i, 3'b000} +: 8] = wr_lo_i[7:0];
      end
      SZ_HALF: begin
        ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        if (lane_i[1]) merged_o[31:16] = wr_lo_i;
        else           merged_o[15:0]  = wr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a single-port word memory: byte/half/word loads and stores,
// read-modify-write for sub-word stores, held response with error flag until taken.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wlo_q, wlo_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  acc_err;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] merged;

  byte_lane_align u_align (
    .size_i    (size_q),
    .signed_i  (sgn_q),
    .lane_i    (addr_q[1:0]),
    .rd_word_i (mem_rdata),
    .wr_lo_i   (wlo_q),
    .ld_data_o (ld_data),
    .merged_o  (merged)
  );

  always_comb begin
    acc_err = 1'b0;
    if (req_size == 2'b11)                                       acc_err = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])                 acc_err = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)      acc_err = 1'b1;
    else if ((req_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS))        acc_err = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    wlo_d       = wlo_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wlo_d   = req_wdata[15:0];
          rdata_d = '0;
          err_d   = acc_err;
          if (acc_err) begin
            state_d = ST_RSP;
          end else if (req_we && req_size == SZ_WORD) begin
            state_d     = ST_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // Sub-word stores come through here to fetch the lanes they must preserve
        if (we_q) begin
          state_d     = ST_WR;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d = ST_RSP;
          rdata_d = ld_data;
        end
      end
      ST_WR:   state_d = ST_RSP;
      ST_RSP:  if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wlo_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wlo_q       <= wlo_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_RSP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q >> 2;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 32-word memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  logic [31:0] mem [0:31];
  int          we_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign mem_rdata = mem[mem_addr[4:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
      we_cnt             <= we_cnt + 1;
      last_waddr         <= mem_addr;
      last_wdata         <= mem_wdata;
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic recv(input string tag);
    int   n = 0;
    exp_t e;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_vld"}, {31'b0, resp_valid}, 32'd1);
    e = sb.pop_front();
    if (resp_valid) begin
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    sb.push_back({exp_rd, exp_err});
    send(we, sz, sg, a, wd);
    recv(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_rvld"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_rerr"}, {31'b0, resp_err}, 32'd0);
    check({tag, "_mwe"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'd0);
    check({tag, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   w0;
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;

    // Word store then load, with one-cycle write pulse and load latency
    w0 = we_cnt;
    xact("st_w8", 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
    check("st_w8_wecnt", we_cnt - w0, 32'd1);
    check("st_w8_waddr", last_waddr, 32'd2);
    check("st_w8_wdata", last_wdata, 32'hDEADBEEF);
    sb.push_back({32'hDEADBEEF, 1'b0});
    send(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    check("ld_lat_rd", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("ld_lat_rsp", {31'b0, resp_valid}, 32'd1);
    recv("ld_w8");
    xact("ld_sb_f", 1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0, 32'hFFFFFFDE, 1'b0);

    // Sub-word read-modify-write
    xact("st_w12", 1'b1, SZ_WORD, 1'b0, 32'hC, 32'hFFFFFFFF, 32'h0, 1'b0);
    w0 = we_cnt;
    xact("st_b13", 1'b1, SZ_BYTE, 1'b0, 32'hD, 32'hABCDEF12, 32'h0, 1'b0);
    check("rmw_wecnt", we_cnt - w0, 32'd1);
    check("rmw_waddr", last_waddr, 32'd3);
    check("rmw_wdata", last_wdata, 32'hFFFF12FF);
    xact("ld_hs_e", 1'b0, SZ_HALF, 1'b1, 32'hE, 32'h0, 32'hFFFFFFFF, 1'b0);
    xact("ld_bu_d", 1'b0, SZ_BYTE, 1'b0, 32'hD, 32'h0, 32'h00000012, 1'b0);
    xact("ld_hu_c", 1'b0, SZ_HALF, 1'b0, 32'hC, 32'h0, 32'h000012FF, 1'b0);
    xact("ld_bs_c", 1'b0, SZ_BYTE, 1'b1, 32'hC, 32'h0, 32'hFFFFFFFF, 1'b0);

    // Error cases never touch memory
    w0 = we_cnt;
    xact("err_wmis", 1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
    xact("err_hmis", 1'b1, SZ_HALF, 1'b0, 32'h3, 32'h1234, 32'h0, 1'b1);
    xact("err_range", 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
    xact("err_size", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1);
    check("err_wecnt", we_cnt - w0, 32'd0);

    // Backpressure: response held while a new request waits
    sb.push_back({32'hDEADBEEF, 1'b0});
    send(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'hC;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", {31'b0, resp_valid}, 32'd1);
      check("bp_rdata", resp_rdata, e.rdata);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_idle_busy", {31'b0, busy}, 32'd0);
    check("bp_idle_ready", {31'b0, req_ready}, 32'd1);
    sb.push_back({32'hFFFF12FF, 1'b0});
    @(negedge clk);
    check("bp_accept_busy", {31'b0, busy}, 32'd1);
    req_valid = 1'b0;
    recv("bp_next");

    // Reset during the write cycle of a byte store
    xact("st_w16", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hAABBCCDD, 32'h0, 1'b0);
    w0 = we_cnt;
    send(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h55);
    check("rms_rd_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    check("rms_wr_we", {31'b0, mem_we}, 32'd1);
    check("rms_wr_addr", mem_addr, 32'd4);
    #1 rst = 1'b1;
    #1 check("rms_async_we", {31'b0, mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rms_post");
    check("rms_wecnt", we_cnt - w0, 32'd0);
    xact("ld_w16", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hAABBCCDD, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
